// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcodes, ALU codes, FSM states and the strobe bundle.
package control_unit_pkg;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
    } state_e;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // The ALU is driven with the opcode value itself for register operations.
    localparam logic [4:0] ALU_ADD = OP_ADD;
    localparam logic [4:0] ALU_AND = OP_AND;
    localparam logic [4:0] ALU_OR  = OP_OR;

    typedef struct packed {
        logic pc_out, pc_in, ir_in, mar_in, mdr_in, mdr_out, y_in, z_in;
        logic zlow_out, zhigh_out, hi_in, lo_in, hi_out, lo_out, c_out, inc_pc;
        logic gra, grb, grc, r_in, r_out, ba_out;
        logic read, write, run, fault;
        logic [4:0] alu_instruction;
    } ctrl_t;

    function automatic logic is_rtype(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL};
    endfunction

    function automatic logic is_itype(input logic [4:0] op);
        return op inside {OP_ADDI, OP_ANDI, OP_ORI};
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return op inside {OP_LD, OP_LDI, OP_ST};
    endfunction

    function automatic logic is_muldiv(input logic [4:0] op);
        return op inside {OP_MUL, OP_DIV};
    endfunction

    function automatic logic [4:0] itype_alu(input logic [4:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_wait_timer.sv
// Memory wait counter: counts cycles of an outstanding access, idles at zero between accesses.
module ctrl_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic clr,
    input  logic waiting,
    output logic first_cycle,
    output logic at_limit
);
    localparam int CW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = waiting ? count_q + CW'(1) : '0;
    end

    // NOTE: state flops take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) count_q <= '0;
        else     count_q <= count_d;
    end

    assign first_cycle = (count_q == '0);
    assign at_limit    = (count_q == CW'(MEM_WAIT_MAX - 1));

endmodule

// File: rtl/control_unit.sv
// Moore control FSM for the datapath; mul/div decode is enabled by defining CTRL_MULDIV_EN.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_done,
    input  logic        stop,
    output logic        pc_out, pc_in, ir_in, mar_in, mdr_in, mdr_out, y_in, z_in,
    output logic        zlow_out, zhigh_out, hi_in, lo_in, hi_out, lo_out, c_out, inc_pc,
    output logic        gra, grb, grc, r_in, r_out, ba_out,
    output logic        read, write,
    output logic [4:0]  alu_instruction,
    output logic        run,
    output logic        fault
);
`ifdef CTRL_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    state_e     state_q, state_d;
    logic       stop_pend_q, stop_pend_d;
    logic [4:0] op;
    logic       in_access, first_cycle, at_limit, expired;
    logic       unused_ir;
    ctrl_t      ctrl;

    assign op        = ir[31:27];
    assign unused_ir = ^ir[26:0];
    assign in_access = (state_q == S_T1) || (state_q == S_T6 && op == OP_LD)
                    || (state_q == S_T7 && op == OP_ST);
    assign expired   = at_limit && !mem_done;

    ctrl_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait (
        .clk        (clk),
        .clr        (clr),
        .waiting    (in_access && !mem_done),
        .first_cycle(first_cycle),
        .at_limit   (at_limit)
    );

    always_comb begin
        state_e next_instr;
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        ctrl        = '0;
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        next_instr  = (stop_pend_q || stop) ? S_HALT : S_T0;
        if (state_q inside {S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7}) begin
            ctrl.run             = 1'b1;
            ctrl.alu_instruction = op;
            stop_pend_d          = stop_pend_q || stop;
        end
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                {ctrl.pc_out, ctrl.mar_in, ctrl.inc_pc, ctrl.z_in} = '1;
                ctrl.alu_instruction = ALU_ADD;
                state_d = S_T1;
            end
            S_T1: begin
                {ctrl.zlow_out, ctrl.pc_in} = {2{first_cycle}};
                {ctrl.read, ctrl.mdr_in}    = '1;
                if (mem_done)     state_d = S_T2;
                else if (expired) state_d = S_FAULT;
            end
            S_T2: begin
                {ctrl.mdr_out, ctrl.ir_in} = '1;
                state_d = S_T3;
            end
            S_T3: begin
                state_d = S_T4;
                if (is_rtype(op) || is_itype(op))    {ctrl.grb, ctrl.r_out, ctrl.y_in}  = '1;
                else if (is_mem(op))                 {ctrl.grb, ctrl.ba_out, ctrl.y_in} = '1;
                else if (is_muldiv(op) && MULDIV_EN) {ctrl.gra, ctrl.r_out, ctrl.y_in}  = '1;
                else begin
                    case (op)
                        OP_MFHI: begin {ctrl.hi_out, ctrl.gra, ctrl.r_in} = '1; state_d = next_instr; end
                        OP_MFLO: begin {ctrl.lo_out, ctrl.gra, ctrl.r_in} = '1; state_d = next_instr; end
                        OP_NOP:  state_d = next_instr;
                        OP_HALT: state_d = S_HALT;
                        default: begin ctrl.alu_instruction = '0; state_d = S_FAULT; end
                    endcase
                end
            end
            S_T4: begin
                state_d = S_T5;
                if (is_rtype(op))       {ctrl.grc, ctrl.r_out, ctrl.z_in} = '1;
                else if (is_itype(op)) begin
                    {ctrl.c_out, ctrl.z_in} = '1;
                    ctrl.alu_instruction    = itype_alu(op);
                end else if (is_mem(op)) begin
                    {ctrl.c_out, ctrl.z_in} = '1;
                    ctrl.alu_instruction    = ALU_ADD;
                end else if (is_muldiv(op) && MULDIV_EN) {ctrl.grb, ctrl.r_out, ctrl.z_in} = '1;
                else state_d = S_FAULT;
            end
            S_T5: begin
                ctrl.zlow_out = 1'b1;
                if (is_rtype(op) || is_itype(op) || op == OP_LDI) begin
                    {ctrl.gra, ctrl.r_in} = '1;
                    state_d = next_instr;
                end else if (op == OP_LD || op == OP_ST) begin
                    ctrl.mar_in = 1'b1;
                    state_d = S_T6;
                end else if (is_muldiv(op) && MULDIV_EN) begin
                    ctrl.lo_in = 1'b1;
                    state_d = S_T6;
                end else begin
                    ctrl.zlow_out = 1'b0;
                    state_d = S_FAULT;
                end
            end
            S_T6: begin
                if (op == OP_LD) begin
                    {ctrl.read, ctrl.mdr_in} = '1;
                    if (mem_done)     state_d = S_T7;
                    else if (expired) state_d = S_FAULT;
                end else if (op == OP_ST) begin
                    {ctrl.gra, ctrl.r_out, ctrl.mdr_in} = '1;
                    state_d = S_T7;
                end else if (is_muldiv(op) && MULDIV_EN) begin
                    {ctrl.zhigh_out, ctrl.hi_in} = '1;
                    state_d = next_instr;
                end else state_d = S_FAULT;
            end
            S_T7: begin
                if (op == OP_LD) begin
                    {ctrl.mdr_out, ctrl.gra, ctrl.r_in} = '1;
                    state_d = next_instr;
                end else if (op == OP_ST) begin
                    ctrl.write = 1'b1;
                    if (mem_done)     state_d = next_instr;
                    else if (expired) state_d = S_FAULT;
                end else state_d = S_FAULT;
            end
            S_FAULT: ctrl.fault = 1'b1;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_RESET;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    assign {pc_out, pc_in, ir_in, mar_in, mdr_in, mdr_out, y_in, z_in} =
        {ctrl.pc_out, ctrl.pc_in, ctrl.ir_in, ctrl.mar_in, ctrl.mdr_in, ctrl.mdr_out, ctrl.y_in, ctrl.z_in};
    assign {zlow_out, zhigh_out, hi_in, lo_in, hi_out, lo_out, c_out, inc_pc} =
        {ctrl.zlow_out, ctrl.zhigh_out, ctrl.hi_in, ctrl.lo_in, ctrl.hi_out, ctrl.lo_out, ctrl.c_out, ctrl.inc_pc};
    assign {gra, grb, grc, r_in, r_out, ba_out} =
        {ctrl.gra, ctrl.grb, ctrl.grc, ctrl.r_in, ctrl.r_out, ctrl.ba_out};
    // A clear in the middle of a wait withdraws the memory request immediately.
    assign read            = ctrl.read  && !clr;
    assign write           = ctrl.write && !clr;
    assign alu_instruction = ctrl.alu_instruction;
    assign run             = ctrl.run;
    assign fault           = ctrl.fault;

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; expectations hold for either CTRL_MULDIV_EN setting.
module tb_control_unit;
    localparam int MAX = 15;

    localparam logic [25:0] PC_OUT = 26'(1) << 25, PC_IN = 26'(1) << 24, IR_IN = 26'(1) << 23;
    localparam logic [25:0] MAR_IN = 26'(1) << 22, MDR_IN = 26'(1) << 21, MDR_OUT = 26'(1) << 20;
    localparam logic [25:0] Y_IN = 26'(1) << 19, Z_IN = 26'(1) << 18, ZLOW = 26'(1) << 17;
    localparam logic [25:0] ZHIGH = 26'(1) << 16, HI_IN = 26'(1) << 15, LO_IN = 26'(1) << 14;
    localparam logic [25:0] HI_OUT = 26'(1) << 13, LO_OUT = 26'(1) << 12, C_OUT = 26'(1) << 11;
    localparam logic [25:0] INC_PC = 26'(1) << 10, GRA = 26'(1) << 9, GRB = 26'(1) << 8;
    localparam logic [25:0] GRC = 26'(1) << 7, R_IN = 26'(1) << 6, R_OUT = 26'(1) << 5;
    localparam logic [25:0] BA_OUT = 26'(1) << 4, READ = 26'(1) << 3, WRITE = 26'(1) << 2;
    localparam logic [25:0] RUN = 26'(1) << 1, FAULT = 26'(1) << 0;
    localparam logic [25:0] T0_EXP = PC_OUT | MAR_IN | INC_PC | Z_IN | RUN;

    localparam logic [4:0] OP_LD = 5'b00000, OP_ST = 5'b00010, OP_ADD = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b00101, OP_ANDI = 5'b01101, OP_MUL = 5'b01111;
    localparam logic [4:0] OP_MFHI = 5'b11000, OP_NOP = 5'b11010, OP_BAD = 5'b11111;

    logic clk = 1'b0, clr, mem_done, stop;
    logic [31:0] ir;
    logic pc_out, pc_in, ir_in, mar_in, mdr_in, mdr_out, y_in, z_in;
    logic zlow_out, zhigh_out, hi_in, lo_in, hi_out, lo_out, c_out, inc_pc;
    logic gra, grb, grc, r_in, r_out, ba_out, read, write, run, fault;
    logic [4:0] alu_instruction;
    int tests_run = 0, fails = 0;

    control_unit #(.MEM_WAIT_MAX(MAX)) dut (
        .clk(clk), .clr(clr), .ir(ir), .mem_done(mem_done), .stop(stop),
        .pc_out(pc_out), .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .mdr_out(mdr_out), .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
        .hi_in(hi_in), .lo_in(lo_in), .hi_out(hi_out), .lo_out(lo_out), .c_out(c_out),
        .inc_pc(inc_pc), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out),
        .ba_out(ba_out), .read(read), .write(write), .alu_instruction(alu_instruction),
        .run(run), .fault(fault)
    );

    always #5 clk = ~clk;

    function automatic logic [25:0] outs();
        return {pc_out, pc_in, ir_in, mar_in, mdr_in, mdr_out, y_in, z_in, zlow_out, zhigh_out,
                hi_in, lo_in, hi_out, lo_out, c_out, inc_pc, gra, grb, grc, r_in, r_out, ba_out,
                read, write, run, fault};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From T0: load an instruction, finish fetch with an immediate mem_done, stop in T3.
    task automatic fetch(input logic [4:0] op);
        ir = {op, 27'h0};
        step();
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        check("fetch_t2", outs(), RUN | MDR_OUT | IR_IN);
        step();
    endtask

    task automatic recover();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("recover_rst", outs(), 26'h0);
        step();
        check("recover_t0", outs(), T0_EXP);
    endtask

    initial begin
        clr = 1'b1; ir = '0; mem_done = 1'b0; stop = 1'b0;
        step();
        step();
        check("clr_outs", outs(), 26'h0);
        clr = 1'b0;
        check("rst_outs", outs(), 26'h0);
        check("rst_alu", alu_instruction, 5'b00000);
        step();
        check("t0", outs(), T0_EXP);
        check("t0_alu", alu_instruction, 5'b00011);

        // add: six cycles from T0 back to T0
        ir = {OP_ADD, 27'h0};
        step();
        check("add_t1", outs(), RUN | ZLOW | PC_IN | READ | MDR_IN);
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        check("add_t2", outs(), RUN | MDR_OUT | IR_IN);
        step(); check("add_t3", outs(), RUN | GRB | R_OUT | Y_IN);
        step(); check("add_t4", outs(), RUN | GRC | R_OUT | Z_IN);
        check("add_t4_alu", alu_instruction, 5'b00011);
        step(); check("add_t5", outs(), RUN | ZLOW | GRA | R_IN);
        step(); check("add_next_t0", outs(), T0_EXP);

        // ld with mem_done in the fourth T6 cycle
        fetch(OP_LD);
        check("ld_t3", outs(), RUN | GRB | BA_OUT | Y_IN);
        step(); check("ld_t4", outs(), RUN | C_OUT | Z_IN);
        check("ld_t4_alu", alu_instruction, 5'b00011);
        step(); check("ld_t5", outs(), RUN | ZLOW | MAR_IN);
        for (int i = 0; i < 4; i++) begin
            step();
            check("ld_t6_read", outs(), RUN | READ | MDR_IN);
            mem_done = (i == 3);
        end
        step();
        mem_done = 1'b0;
        check("ld_t7", outs(), RUN | MDR_OUT | GRA | R_IN);
        step(); check("ld_next_t0", outs(), T0_EXP);

        // andi uses the constant path and the AND ALU code
        fetch(OP_ANDI);
        check("andi_t3", outs(), RUN | GRB | R_OUT | Y_IN);
        step(); check("andi_t4", outs(), RUN | C_OUT | Z_IN);
        check("andi_t4_alu", alu_instruction, OP_AND);
        step(); check("andi_t5", outs(), RUN | ZLOW | GRA | R_IN);
        step(); check("andi_next_t0", outs(), T0_EXP);

        fetch(OP_MFHI);
        check("mfhi_t3", outs(), RUN | HI_OUT | GRA | R_IN);
        step(); check("mfhi_next_t0", outs(), T0_EXP);

        fetch(OP_MUL);
`ifdef CTRL_MULDIV_EN
        check("mul_t3", outs(), RUN | GRA | R_OUT | Y_IN);
        step(); check("mul_t4", outs(), RUN | GRB | R_OUT | Z_IN);
        check("mul_t4_alu", alu_instruction, OP_MUL);
        step(); check("mul_t5", outs(), RUN | ZLOW | LO_IN);
        step(); check("mul_t6", outs(), RUN | ZHIGH | HI_IN);
        step(); check("mul_next_t0", outs(), T0_EXP);
`else
        check("mul_t3_nostrobe", outs(), RUN);
        step(); check("mul_fault", outs(), FAULT);
        recover();
`endif

        // illegal opcode
        fetch(OP_BAD);
        check("bad_t3_nostrobe", outs(), RUN);
        step(); check("bad_fault", outs(), FAULT);
        check("bad_fault_alu", alu_instruction, 5'b00000);
        step(); check("bad_fault_held", outs(), FAULT);
        recover();

        // fetch timeout: read held MAX cycles, then FAULT
        ir = {OP_NOP, 27'h0};
        for (int i = 0; i < MAX; i++) begin
            step();
            check("to_read_held", outs() & READ, READ);
        end
        step();
        check("to_fault", outs(), FAULT);
        recover();

        // clear during a fetch wait drops read at once
        step();
        step();
        check("midwait_read", outs() & READ, READ);
        clr = 1'b1;
        #1;
        check("midwait_clr_cancel", outs() & (READ | WRITE), 26'h0);
        step();
        clr = 1'b0;
        check("midwait_rst", outs(), 26'h0);
        step(); check("midwait_t0", outs(), T0_EXP);

        // st with stop pulsed in T4
        fetch(OP_ST);
        check("st_t3", outs(), RUN | GRB | BA_OUT | Y_IN);
        step();
        stop = 1'b1;
        check("st_t4", outs(), RUN | C_OUT | Z_IN);
        step();
        stop = 1'b0;
        check("st_t5", outs(), RUN | ZLOW | MAR_IN);
        step(); check("st_t6", outs(), RUN | GRA | R_OUT | MDR_IN);
        step(); check("st_t7_write", outs(), RUN | WRITE);
        step(); check("st_t7_write_held", outs(), RUN | WRITE);
        mem_done = 1'b1;
        step();
        mem_done = 1'b0;
        check("st_halt", outs(), 26'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_held", outs(), 26'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15, max cycles a memory access may wait for mem_done before FAULT.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 clr  in  1  reset; synchronous, active-high.
REQ-004 ir  in  32  instruction register contents (opcode = ir[31:27]).
REQ-005 mem_done  in  1  memory handshake; access completes in the cycle it is high.
REQ-006 stop  in  1  request halt at next instruction boundary.
REQ-007 pc_out, pc_in, ir_in, mar_in, mdr_in, mdr_out, y_in, z_in  out  1 each  datapath strobes.
REQ-008 zlow_out, zhigh_out, hi_in, lo_in, hi_out, lo_out, c_out, inc_pc  out  1 each  datapath strobes.
REQ-009 gra, grb, grc, r_in, r_out, ba_out  out  1 each  register-select encoder controls.
REQ-010 read, write  out  1 each  memory access requests, held until mem_done.
REQ-011 alu_instruction  out  5  ALU opcode.
REQ-012 run  out  1  high while fetching/executing; low in HALT and FAULT.
REQ-013 fault  out  1  high only in FAULT.

Function
REQ-014 States SHALL be RESET, T0-T7, HALT, FAULT, held in one encoded state register; outputs decoded from state and opcode (Moore).
REQ-015 Fetch: T0 = pc_out, mar_in, inc_pc, z_in; T1 = zlow_out, pc_in (first cycle only), read, mdr_in until mem_done; T2 = mdr_out, ir_in.
REQ-016 R-type (add, sub, and, or, shr, shra, shl, ror, rol): T3 grb,r_out,y_in; T4 grc,r_out,z_in, alu_instruction = opcode; T5 zlow_out,gra,r_in; then T0.
REQ-017 I-type (addi, andi, ori): as REQ-016 but T4 uses c_out in place of grc,r_out; alu_instruction = matching ALU op.
REQ-018 ld/ldi: T3 grb,ba_out,y_in; T4 c_out,z_in, ADD; T5 zlow_out then (ldi) gra,r_in -> T0, or (ld) mar_in; T6 read,mdr_in until mem_done; T7 mdr_out,gra,r_in.
REQ-019 st: T3-T5 as ld; T6 gra,r_out,mdr_in; T7 write until mem_done.
REQ-020 mfhi/mflo: T3 hi_out (or lo_out), gra, r_in; then T0. nop: T3 -> T0 with no strobes.
REQ-021 halt opcode or stop sampled high in T2/last execute state SHALL enter HALT after the current instruction; HALT held until clr.
REQ-022 Unlisted opcode in T3 SHALL enter FAULT with no strobes asserted; FAULT held until clr.
REQ-023 Wait counter SHALL clear on each access entry; reaching MEM_WAIT_MAX without mem_done SHALL enter FAULT, dropping read/write.
REQ-024 read and write SHALL never be high together; mdr_in stays asserted with read while waiting.
REQ-025 alu_instruction SHALL be ADD during T0 and address calculation, opcode otherwise, 0 when idle.

Reset
REQ-026 clr high SHALL force RESET next edge from any state, including mid memory wait, cancelling read/write that cycle.
REQ-027 In RESET all outputs SHALL be 0; RESET -> T0 on first edge with clr low.

Configuration
REQ-028 Macro CTRL_MULDIV_EN defined: mul/div decoded as T3 gra,r_out,y_in; T4 grb,r_out,z_in, opcode; T5 zlow_out,lo_in; T6 zhigh_out,hi_in; then T0.
REQ-029 CTRL_MULDIV_EN undefined: mul/div opcodes SHALL be treated as illegal (FAULT).

Structure
REQ-030 Shared package SHALL hold 5-bit opcode constants, ALU op codes and the state enumeration.
REQ-031 One sub-module, ctrl_wait_timer, SHALL implement the memory wait counter; decode stays in control_unit.

Verification
REQ-032 clr 2 cycles, release -> all outputs 0 in RESET, pc_out=mar_in=inc_pc=1 one cycle later.
REQ-033 add R1,R2,R3 with mem_done at first T1 cycle -> z_in with alu_instruction=00011 in T4, gra+r_in in T5, 6 cycles total.
REQ-034 ld with mem_done delayed 3 cycles in T6 -> read,mdr_in held exactly 4 cycles, then mdr_out,gra,r_in.
REQ-035 mem_done never asserted in T1 -> fault=1, run=0 after MEM_WAIT_MAX cycles; clr recovers to RESET.
REQ-036 opcode 11111 -> FAULT at T3; mul with CTRL_MULDIV_EN -> lo_in in T5, hi_in in T6, without it -> FAULT.
REQ-037 stop pulsed during T4 of st -> write completes, then HALT with run=0, no further pc_out.
